idex_stage: RTL and testbench
=============================

# idex_stage

ID/EX pipeline register for the 5-stage core with integrated load-use hazard detection. It captures decoded operands and control from ID and presents the registered `idex_*` fields consumed by EX and by forwarding control. It also raises a same-cycle stall toward PC/IF-ID on a load-use dependency, inserts exactly one bubble, and handles branch flush and downstream hold.

## Interface
Parameters:
- XLEN, 32, datapath width
- RA, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2, id_rd  in  RA each  decoded register addresses
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data, id_imm, id_pc  in  XLEN each  operands, immediate, PC
- id_regw, id_memr, id_memw, id_memtoreg, id_alusrc  in  1 each  control
- id_aluop  in  2  ALU op class
- flush_ex  in  1  branch/jump taken in EX; kill the instruction now in ID
- ex_hold  in  1  downstream multi-cycle hold; freeze ID/EX
- idex_valid  out  1  registered valid
- idex_rs1, idex_rs2, idex_rd  out  RA each  registered addresses
- idex_rs1_data, idex_rs2_data, idex_imm, idex_pc  out  XLEN each
- idex_regw, idex_memr, idex_memw, idex_memtoreg, idex_alusrc  out  1 each
- idex_aluop  out  2
- stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble  out  1  registered; current ID/EX content is an inserted bubble

## Operation
- Load-use hazard (lu): idex_valid & idex_memr & (idex_rd != 0) & id_valid & ((id_use_rs1 & idex_rd == id_rs1) | (id_use_rs2 & idex_rd == id_rs2)).
- Next-state priority, evaluated each rising edge:
  1. rst: all outputs 0.
  2. flush_ex: load a bubble.
  3. ex_hold: all registers keep their values.
  4. lu: load a bubble.
  5. Otherwise: load the ID fields. idex_valid = id_valid. Control fields are ANDed with id_valid.
- Bubble: idex_valid and all control outputs are 0, and bubble = 1. Addresses and data are don't-care; the implementation zeroes them so waveforms stay deterministic.
- bubble is 1 only when the bubble comes from priority 2 or 4, or from a load with id_valid = 0. It is 0 after reset.
- stall = ~flush_ex & (ex_hold | lu). A flush always wins: the wrong-path instruction in ID is discarded and is never held.
- x0 never creates a hazard. A store whose rs2 matches the load rd still stalls; no store-data forwarding exists in MEM.

## Timing
- Latency: ID fields appear on the idex_* outputs one cycle after capture.
- Load-use: stall is asserted in the same cycle lu is true. The next edge inserts exactly one bubble.
  - The cycle after that edge, the load is in EX/MEM and lu is false. The dependent instruction advances, and forwarding from MEM/WB covers it.
- Back-to-back loads into the same dependent instruction give one bubble per load, never two per load.
- ex_hold with lu: the registers hold, so the load stays in ID/EX and lu stays true; no bubble is inserted while held. When ex_hold falls, lu is re-evaluated and a single bubble follows.
- Reset mid-stall: the next edge clears everything. stall is 0 in the cycle after reset, because idex_valid = 0.

## Configuration
- IDEX_STALL_CNT_EN defined: adds output port stall_cnt, 32 bits.
  - Increments on every edge where a load-use bubble is inserted (priority 4).
  - Saturates at 0xFFFFFFFF and clears on rst.
- IDEX_STALL_CNT_EN undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg holds:
  - the ctrl_t packed struct (regw, memr, memw, memtoreg, alusrc, aluop);
  - the ALUOP_* 2-bit constants;
  - the CTRL_NOP constant, used for bubbles.
- One sub-module, hazard_detect: purely combinational, producing lu from the idex_* and id_* address and control fields. The register and priority logic stays in idex_stage.

## Test plan
- Plain flow: add x3,x1,x2 with id_valid = 1 -> next cycle idex_rd = 3, idex_regw = 1, bubble = 0, stall = 0 throughout.
- Load-use: lw x5 in ID/EX and add x6,x5,x7 in ID -> stall = 1 that cycle; next cycle bubble = 1, idex_valid = 0, stall = 0; following cycle idex_rd = 6.
- x0 / unused operand: lw x0 followed by add using x0 -> no stall. lw x5 followed by an instruction with id_use_rs2 = 0 and rs2 = 5 -> no stall.
- Flush with lu: flush_ex = 1 in the same cycle as lu -> stall = 0; next cycle bubble = 1; stall_cnt unchanged.
- Hold: lu present with ex_hold = 1 for 3 cycles -> outputs frozen and stall = 1 for 3 cycles; after release, one bubble, and stall_cnt increments by 1.
- Reset: rst during a stall -> next cycle all outputs 0, stall = 0, stall_cnt = 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage core: control bundle layout,
// ALU operation classes and the all-zero control word used for bubbles.
package pipe_pkg;

    // ALU operation classes decoded in ID and refined by EX
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_BRANCH = 2'b11;

    // Control bundle carried from ID into EX
    typedef struct packed {
        logic       regw;
        logic       memr;
        logic       memw;
        logic       memtoreg;
        logic       alusrc;
        logic [1:0] aluop;
    } ctrl_t;

    // Control word of an inserted bubble: no side effects anywhere downstream
    localparam ctrl_t CTRL_NOP = '{
        regw:     1'b0,
        memr:     1'b0,
        memw:     1'b0,
        memtoreg: 1'b0,
        alusrc:   1'b0,
        aluop:    ALUOP_ADD
    };

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an instruction in ID that reads the
// destination of a load currently sitting in ID/EX. Purely combinational.
// x0 never matches, and operands the instruction does not read are ignored.
module hazard_detect #(
    parameter int RA = 5
) (
    input  logic          idex_valid,
    input  logic          idex_memr,
    input  logic [RA-1:0] idex_rd,
    input  logic          id_valid,
    input  logic [RA-1:0] id_rs1,
    input  logic [RA-1:0] id_rs2,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    output logic          lu
);

    logic load_in_ex;
    logic rs1_hit;
    logic rs2_hit;

    // A store whose rs2 matches still counts: MEM has no store-data forwarding
    assign load_in_ex = idex_valid & idex_memr & (idex_rd != '0);
    assign rs1_hit    = id_use_rs1 & (idex_rd == id_rs1);
    assign rs2_hit    = id_use_rs2 & (idex_rd == id_rs2);
    assign lu         = load_in_ex & id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use stall and single-bubble insertion.
// Edge priority: rst > flush_ex > ex_hold > load-use > normal capture.
// Optional feature: define IDEX_STALL_CNT_EN to add the 32-bit saturating
// stall_cnt output counting load-use bubbles.
module idex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RA-1:0]   id_rs1,
    input  logic [RA-1:0]   id_rs2,
    input  logic [RA-1:0]   id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic            id_regw,
    input  logic            id_memr,
    input  logic            id_memw,
    input  logic            id_memtoreg,
    input  logic            id_alusrc,
    input  logic [1:0]      id_aluop,
    input  logic            flush_ex,
    input  logic            ex_hold,
    output logic            idex_valid,
    output logic [RA-1:0]   idex_rs1,
    output logic [RA-1:0]   idex_rs2,
    output logic [RA-1:0]   idex_rd,
    output logic [XLEN-1:0] idex_rs1_data,
    output logic [XLEN-1:0] idex_rs2_data,
    output logic [XLEN-1:0] idex_imm,
    output logic [XLEN-1:0] idex_pc,
    output logic            idex_regw,
    output logic            idex_memr,
    output logic            idex_memw,
    output logic            idex_memtoreg,
    output logic            idex_alusrc,
    output logic [1:0]      idex_aluop,
    output logic            stall,
    output logic            bubble
`ifdef IDEX_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    ctrl_t id_ctrl;
    ctrl_t ctrl_q;
    logic  lu;
    logic  take_bubble;
    logic  lu_bubble;

    assign id_ctrl = '{
        regw:     id_regw,
        memr:     id_memr,
        memw:     id_memw,
        memtoreg: id_memtoreg,
        alusrc:   id_alusrc,
        aluop:    id_aluop
    };

    hazard_detect #(.RA(RA)) u_hazard_detect (
        .idex_valid (idex_valid),
        .idex_memr  (ctrl_q.memr),
        .idex_rd    (idex_rd),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .lu         (lu)
    );

    // A flush always wins, so the wrong-path instruction in ID is never held
    assign stall = ~flush_ex & (ex_hold | lu);

    // Load-use bubble proper (what stall_cnt counts)
    assign lu_bubble = ~flush_ex & ~ex_hold & lu;

    // Any edge that leaves an empty slot in ID/EX: flush, load-use, or an
    // empty ID when not held. All of these share the zeroed bubble image.
    assign take_bubble = flush_ex | (~ex_hold & (lu | ~id_valid));

    // ID/EX register: reset, bubble load, hold, or capture of a valid ID slot
    always_ff @(posedge clk) begin
        // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
        if (rst) begin
            idex_valid    <= 1'b0;
            idex_rs1      <= '0;
            idex_rs2      <= '0;
            idex_rd       <= '0;
            idex_rs1_data <= '0;
            idex_rs2_data <= '0;
            idex_imm      <= '0;
            idex_pc       <= '0;
            ctrl_q        <= CTRL_NOP;
            bubble        <= 1'b0;
        end else if (take_bubble) begin
            idex_valid    <= 1'b0;
            idex_rs1      <= '0;
            idex_rs2      <= '0;
            idex_rd       <= '0;
            idex_rs1_data <= '0;
            idex_rs2_data <= '0;
            idex_imm      <= '0;
            idex_pc       <= '0;
            ctrl_q        <= CTRL_NOP;
            bubble        <= 1'b1;
        end else if (!ex_hold) begin
            // id_valid is known to be 1 here, so control needs no extra gating
            idex_valid    <= 1'b1;
            idex_rs1      <= id_rs1;
            idex_rs2      <= id_rs2;
            idex_rd       <= id_rd;
            idex_rs1_data <= id_rs1_data;
            idex_rs2_data <= id_rs2_data;
            idex_imm      <= id_imm;
            idex_pc       <= id_pc;
            ctrl_q        <= id_ctrl;
            bubble        <= 1'b0;
        end
    end

    assign idex_regw     = ctrl_q.regw;
    assign idex_memr     = ctrl_q.memr;
    assign idex_memw     = ctrl_q.memw;
    assign idex_memtoreg = ctrl_q.memtoreg;
    assign idex_alusrc   = ctrl_q.alusrc;
    assign idex_aluop    = ctrl_q.aluop;

`ifdef IDEX_STALL_CNT_EN
    // Saturating count of load-use bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (lu_bubble && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    logic unused_lu_bubble;
    assign unused_lu_bubble = lu_bubble;
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage: directed scenarios plus a randomized
// run checked against a rule-level model of the ID/EX slot.
module tb_idex_stage;
    import pipe_pkg::*;

    localparam int XLEN = 32;
    localparam int RA   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [RA-1:0]   id_rs1, id_rs2, id_rd;
    logic            id_use_rs1, id_use_rs2;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic            id_regw, id_memr, id_memw, id_memtoreg, id_alusrc;
    logic [1:0]      id_aluop;
    logic            flush_ex, ex_hold;
    logic            idex_valid;
    logic [RA-1:0]   idex_rs1, idex_rs2, idex_rd;
    logic [XLEN-1:0] idex_rs1_data, idex_rs2_data, idex_imm, idex_pc;
    logic            idex_regw, idex_memr, idex_memw, idex_memtoreg, idex_alusrc;
    logic [1:0]      idex_aluop;
    logic            stall, bubble;
`ifdef IDEX_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    idex_stage #(.XLEN(XLEN), .RA(RA)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_pc         (id_pc),
        .id_regw       (id_regw),
        .id_memr       (id_memr),
        .id_memw       (id_memw),
        .id_memtoreg   (id_memtoreg),
        .id_alusrc     (id_alusrc),
        .id_aluop      (id_aluop),
        .flush_ex      (flush_ex),
        .ex_hold       (ex_hold),
        .idex_valid    (idex_valid),
        .idex_rs1      (idex_rs1),
        .idex_rs2      (idex_rs2),
        .idex_rd       (idex_rd),
        .idex_rs1_data (idex_rs1_data),
        .idex_rs2_data (idex_rs2_data),
        .idex_imm      (idex_imm),
        .idex_pc       (idex_pc),
        .idex_regw     (idex_regw),
        .idex_memr     (idex_memr),
        .idex_memw     (idex_memw),
        .idex_memtoreg (idex_memtoreg),
        .idex_alusrc   (idex_alusrc),
        .idex_aluop    (idex_aluop),
        .stall         (stall),
        .bubble        (bubble)
`ifdef IDEX_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    // ---------------- reference model: what the ID/EX slot should hold ----
    logic            m_valid, m_bubble;
    logic [RA-1:0]   m_rs1, m_rs2, m_rd;
    logic [XLEN-1:0] m_rs1_data, m_rs2_data, m_imm, m_pc;
    logic [6:0]      m_ctrl;   // {regw, memr, memw, memtoreg, alusrc, aluop}
    logic [31:0]     m_cnt;

    // Does the instruction in ID read the register a load in EX will write?
    function automatic bit model_lu();
        bit reads_rd;
        reads_rd = (id_use_rs1 && (id_rs1 == m_rd)) || (id_use_rs2 && (id_rs2 == m_rd));
        return m_valid && m_ctrl[5] && (m_rd != 0) && id_valid && reads_rd;
    endfunction

    function automatic bit model_stall();
        return !flush_ex && (ex_hold || model_lu());
    endfunction

    task automatic model_empty_slot(input logic is_bubble);
        m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_rs1_data = 0; m_rs2_data = 0; m_imm = 0; m_pc = 0;
        m_ctrl = 0; m_bubble = is_bubble;
    endtask

    // Apply one clock edge's worth of rules to the model, using current inputs
    task automatic model_edge();
        if (rst) begin
            model_empty_slot(1'b0);
            m_cnt = 0;
        end else if (flush_ex) begin
            model_empty_slot(1'b1);
        end else if (ex_hold) begin
            // slot unchanged
        end else if (model_lu()) begin
            model_empty_slot(1'b1);
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else if (!id_valid) begin
            model_empty_slot(1'b1);
        end else begin
            m_valid = 1; m_bubble = 0;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_rs1_data = id_rs1_data; m_rs2_data = id_rs2_data;
            m_imm = id_imm; m_pc = id_pc;
            m_ctrl = {id_regw, id_memr, id_memw, id_memtoreg, id_alusrc, id_aluop};
        end
    endtask

    // Advance one cycle; outputs are then observed 1 time unit after the edge
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Put an instruction in ID: loads are lw rd, imm(rs1); others are R-type
    task automatic set_id(input logic v, input logic [RA-1:0] rd, input logic [RA-1:0] rs1,
                          input logic [RA-1:0] rs2, input logic u1, input logic u2,
                          input logic is_load);
        id_valid    = v;
        id_rd       = rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_regw     = 1'b1;
        id_memr     = is_load;
        id_memw     = 1'b0;
        id_memtoreg = is_load;
        id_alusrc   = is_load;
        id_aluop    = is_load ? ALUOP_ADD : ALUOP_FUNCT;
        id_rs1_data = 32'h1000_0000 | 32'(rs1);
        id_rs2_data = 32'h2000_0000 | 32'(rs2);
        id_imm      = 32'h0000_0040 + 32'(rd);
        id_pc       = 32'h0000_8000 + {27'd0, rd} * 4;
    endtask

    // ---------------- directed scenarios ----------------------------------
    task automatic test_reset();
        rst = 1; flush_ex = 0; ex_hold = 0;
        set_id(1, 5'd9, 5'd9, 5'd9, 1, 1, 1);
        step();
        vectors++;
        if ({idex_valid, idex_rs1, idex_rs2, idex_rd, idex_rs1_data, idex_rs2_data, idex_imm,
             idex_pc, idex_regw, idex_memr, idex_memw, idex_memtoreg, idex_alusrc, idex_aluop,
             bubble} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b rd=%0d regw=%b memr=%b bubble=%b, want all 0",
                     idex_valid, idex_rd, idex_regw, idex_memr, bubble);
        end
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall); end
`ifdef IDEX_STALL_CNT_EN
        vectors++;
        if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
`endif
        rst = 0;
    endtask

    task automatic test_plain_flow();
        set_id(1, 5'd3, 5'd1, 5'd2, 1, 1, 0);   // add x3,x1,x2
        #1;
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL plain_stall0: got %b want 0", stall); end
        step();
        vectors++;
        if ({idex_valid, idex_rd, idex_regw, idex_memr, bubble} !== {1'b1, 5'd3, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL plain_fields: got valid=%b rd=%0d regw=%b memr=%b bubble=%b, want 1 3 1 0 0",
                     idex_valid, idex_rd, idex_regw, idex_memr, bubble);
        end
        vectors++;
        if ({idex_rs1_data, idex_rs2_data} !== {32'h1000_0001, 32'h2000_0002}) begin
            miscompares++;
            $display("FAIL plain_data: got %h %h want 10000001 20000002", idex_rs1_data, idex_rs2_data);
        end
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL plain_stall1: got %b want 0", stall); end
    endtask

    task automatic test_load_use();
        logic [31:0] cnt0;
        set_id(1, 5'd5, 5'd1, 5'd0, 1, 0, 1);   // lw x5
        step();
        set_id(1, 5'd6, 5'd5, 5'd7, 1, 1, 0);   // add x6,x5,x7
        #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall: got %b want 1", stall); end
`ifdef IDEX_STALL_CNT_EN
        cnt0 = stall_cnt;
`else
        cnt0 = 0;
`endif
        step();
        vectors++;
        if ({bubble, idex_valid, idex_regw, idex_memr, stall} !== 5'b10000) begin
            miscompares++;
            $display("FAIL lu_bubble: got bubble=%b valid=%b regw=%b memr=%b stall=%b, want 1 0 0 0 0",
                     bubble, idex_valid, idex_regw, idex_memr, stall);
        end
`ifdef IDEX_STALL_CNT_EN
        vectors++;
        if (stall_cnt !== cnt0 + 32'd1) begin
            miscompares++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, cnt0 + 32'd1);
        end
`endif
        step();
        vectors++;
        if ({idex_valid, idex_rd, bubble} !== {1'b1, 5'd6, 1'b0}) begin
            miscompares++;
            $display("FAIL lu_advance: got valid=%b rd=%0d bubble=%b, want 1 6 0", idex_valid, idex_rd, bubble);
        end
        if (cnt0 == 32'hFFFF_FFFF) $display("note: counter already saturated");
    endtask

    task automatic test_x0_unused();
        set_id(1, 5'd0, 5'd1, 5'd0, 1, 0, 1);   // lw x0
        step();
        set_id(1, 5'd1, 5'd0, 5'd0, 1, 1, 0);   // add x1,x0,x0
        #1;
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL x0_stall: got %b want 0", stall); end
        step();
        set_id(1, 5'd5, 5'd1, 5'd0, 1, 0, 1);   // lw x5
        step();
        set_id(1, 5'd8, 5'd1, 5'd5, 1, 0, 0);   // rs2 = 5 but not read
        #1;
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL unused_stall: got %b want 0", stall); end
        step();
        vectors++;
        if ({idex_valid, idex_rd, bubble} !== {1'b1, 5'd8, 1'b0}) begin
            miscompares++;
            $display("FAIL unused_advance: got valid=%b rd=%0d bubble=%b, want 1 8 0", idex_valid, idex_rd, bubble);
        end
    endtask

    task automatic test_flush_lu();
        set_id(1, 5'd5, 5'd1, 5'd0, 1, 0, 1);   // lw x5
        step();
        set_id(1, 5'd6, 5'd5, 5'd7, 1, 1, 0);   // dependent add
        flush_ex = 1;
        #1;
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b want 0", stall); end
`ifdef IDEX_STALL_CNT_EN
        begin
            logic [31:0] cnt0;
            cnt0 = stall_cnt;
            step();
            vectors++;
            if (stall_cnt !== cnt0) begin
                miscompares++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, cnt0);
            end
        end
`else
        step();
`endif
        flush_ex = 0;
        vectors++;
        if ({bubble, idex_valid, idex_regw} !== 3'b100) begin
            miscompares++;
            $display("FAIL flush_bubble: got bubble=%b valid=%b regw=%b, want 1 0 0", bubble, idex_valid, idex_regw);
        end
    endtask

    task automatic test_hold();
        logic [31:0] cnt0;
        set_id(1, 5'd5, 5'd1, 5'd0, 1, 0, 1);   // lw x5
        step();
        set_id(1, 5'd6, 5'd5, 5'd7, 1, 1, 0);   // dependent add
        ex_hold = 1;
`ifdef IDEX_STALL_CNT_EN
        cnt0 = stall_cnt;
`else
        cnt0 = 0;
`endif
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (stall !== 1'b1) begin miscompares++; $display("FAIL hold_stall[%0d]: got %b want 1", i, stall); end
            step();
            vectors++;
            if ({idex_valid, idex_rd, idex_memr, bubble} !== {1'b1, 5'd5, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL hold_frozen[%0d]: got valid=%b rd=%0d memr=%b bubble=%b, want 1 5 1 0",
                         i, idex_valid, idex_rd, idex_memr, bubble);
            end
        end
        ex_hold = 0;
        #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL hold_release_stall: got %b want 1", stall); end
        step();
        vectors++;
        if ({bubble, idex_valid} !== 2'b10) begin
            miscompares++; $display("FAIL hold_bubble: got bubble=%b valid=%b want 1 0", bubble, idex_valid);
        end
`ifdef IDEX_STALL_CNT_EN
        vectors++;
        if (stall_cnt !== cnt0 + 32'd1) begin
            miscompares++; $display("FAIL hold_cnt: got %0d want %0d", stall_cnt, cnt0 + 32'd1);
        end
`endif
        step();
        vectors++;
        if ({idex_valid, idex_rd, bubble} !== {1'b1, 5'd6, 1'b0}) begin
            miscompares++;
            $display("FAIL hold_advance: got valid=%b rd=%0d bubble=%b, want 1 6 0", idex_valid, idex_rd, bubble);
        end
        if (cnt0 == 32'hFFFF_FFFF) $display("note: counter already saturated");
    endtask

    task automatic test_back_to_back();
        set_id(1, 5'd5, 5'd1, 5'd0, 1, 0, 1);   // lw x5
        step();
        set_id(1, 5'd6, 5'd5, 5'd0, 1, 0, 1);   // lw x6, 0(x5)
        step();
        vectors++;
        if ({bubble, stall} !== 2'b10) begin
            miscompares++; $display("FAIL b2b_first: got bubble=%b stall=%b want 1 0", bubble, stall);
        end
        step();
        set_id(1, 5'd7, 5'd6, 5'd6, 1, 1, 0);   // add x7,x6,x6
        #1;
        vectors++;
        if ({idex_rd, idex_memr, stall} !== {5'd6, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_second_lu: got rd=%0d memr=%b stall=%b want 6 1 1", idex_rd, idex_memr, stall);
        end
        step();
        vectors++;
        if ({bubble, stall} !== 2'b10) begin
            miscompares++; $display("FAIL b2b_second: got bubble=%b stall=%b want 1 0", bubble, stall);
        end
        step();
        vectors++;
        if ({idex_rd, bubble} !== {5'd7, 1'b0}) begin
            miscompares++; $display("FAIL b2b_advance: got rd=%0d bubble=%b want 7 0", idex_rd, bubble);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_id(1, 5'd5, 5'd1, 5'd0, 1, 0, 1);   // lw x5
        step();
        set_id(1, 5'd6, 5'd5, 5'd7, 1, 1, 0);
        #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre: got %b want 1", stall); end
        rst = 1;
        step();
        rst = 0;
        #1;
        vectors++;
        if ({idex_valid, idex_rd, idex_memr, idex_regw, idex_pc, bubble, stall} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_clear: got valid=%b rd=%0d memr=%b bubble=%b stall=%b, want all 0",
                     idex_valid, idex_rd, idex_memr, bubble, stall);
        end
`ifdef IDEX_STALL_CNT_EN
        vectors++;
        if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL rstmid_cnt: got %0d want 0", stall_cnt); end
`endif
    endtask

    // ---------------- randomized run against the model ---------------------
    task automatic test_random();
        rst = 1; flush_ex = 0; ex_hold = 0;
        step();
        rst = 0;
        for (int n = 0; n < 600; n++) begin
            set_id($urandom_range(0, 99) < 85, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 99) < 40);
            id_rs1_data = $urandom;
            id_rs2_data = $urandom;
            id_imm      = $urandom;
            id_pc       = $urandom;
            id_memw     = 1'($urandom_range(0, 1));
            id_aluop    = 2'($urandom_range(0, 3));
            flush_ex    = $urandom_range(0, 99) < 10;
            ex_hold     = $urandom_range(0, 99) < 15;
            rst         = $urandom_range(0, 99) < 2;
            #1;
            vectors++;
            if (stall !== model_stall()) begin
                miscompares++; $display("FAIL rand_stall[%0d]: got %b want %b", n, stall, model_stall());
            end
            step();
            vectors++;
            if ({idex_valid, idex_regw, idex_memr, idex_memw, idex_memtoreg, idex_alusrc, idex_aluop, bubble}
                !== {m_valid, m_ctrl, m_bubble}) begin
                miscompares++;
                $display("FAIL rand_ctrl[%0d]: got valid=%b ctrl=%b bubble=%b want %b %b %b", n, idex_valid,
                         {idex_regw, idex_memr, idex_memw, idex_memtoreg, idex_alusrc, idex_aluop}, bubble,
                         m_valid, m_ctrl, m_bubble);
            end
            if (m_valid) begin
                vectors++;
                if ({idex_rs1, idex_rs2, idex_rd, idex_rs1_data, idex_rs2_data, idex_imm, idex_pc}
                    !== {m_rs1, m_rs2, m_rd, m_rs1_data, m_rs2_data, m_imm, m_pc}) begin
                    miscompares++;
                    $display("FAIL rand_data[%0d]: got rd=%0d pc=%h imm=%h want rd=%0d pc=%h imm=%h",
                             n, idex_rd, idex_pc, idex_imm, m_rd, m_pc, m_imm);
                end
            end
`ifdef IDEX_STALL_CNT_EN
            vectors++;
            if (stall_cnt !== m_cnt) begin
                miscompares++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, stall_cnt, m_cnt);
            end
`endif
        end
        rst = 0; flush_ex = 0; ex_hold = 0;
    endtask

    initial begin
        rst = 1; flush_ex = 0; ex_hold = 0;
        set_id(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        model_empty_slot(1'b0);
        m_cnt = 0;
        test_reset();
        test_plain_flow();
        test_load_use();
        test_x0_unused();
        test_flush_lu();
        test_hold();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
